start_sw_capture: RTL and testbench

Input-capture front end for the counting game: synchronizes the raw `start` key and the 7 game switches, debounces `start`, and turns each qualified press into a single-cycle `go` strobe. On that strobe it latches the switch word and its population count for the game core. It sits between the board pins (`start`, `sw`) and `game_top`'s control logic. It is the receiving end of the stimulus the board or bench drives into the game.

---
 rtl/start_sw_capture_if.sv | 26 ++
 rtl/start_sw_capture.sv | 159 +++++++++++++++
 tb/tb_start_sw_capture.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/start_sw_capture_if.sv
// Board-side bundle for the start/switch capture block: raw pins and busy in,
// press strobes and the latched switch word out.
`timescale 1ns/1ps
interface start_sw_capture_if #(
    parameter int SW_W = 7
);
    logic            start;
    logic [SW_W-1:0] sw;
    logic            busy;
    logic            go;
    logic            rej;
    logic [SW_W-1:0] sw_q;
    logic [2:0]      ones;
    logic [7:0]      press_cnt;
    logic            sw_chg;

    modport master (
        output start, sw, busy,
        input  go, rej, sw_q, ones, press_cnt, sw_chg
    );

    modport slave (
        input  start, sw, busy,
        output go, rej, sw_q, ones, press_cnt, sw_chg
    );
endinterface

// File: rtl/start_sw_capture.sv
// Synchronizes and debounces the start key, emits go/rej once per qualified
// press, and latches the switch word with its population count on go.
`timescale 1ns/1ps
module start_sw_capture #(
    parameter int SW_W      = 7,
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    start_sw_capture_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    function automatic logic [2:0] popcnt(input logic [SW_W-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < SW_W; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    logic [1:0]      start_sync_q, start_sync_d;
    logic [SW_W-1:0] sw_sync1_q, sw_sync1_d;
    logic [SW_W-1:0] sw_sync2_q, sw_sync2_d;
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            go_q, go_d;
    logic            rej_q, rej_d;
    logic [SW_W-1:0] sw_lat_q, sw_lat_d;
    logic [2:0]      ones_q, ones_d;
    logic [7:0]      press_cnt_q, press_cnt_d;
    logic            sw_chg_q, sw_chg_d;

    logic            start_s;
    logic [SW_W-1:0] sw_s;
    logic            qual_s;

    assign start_s = start_sync_q[1];
    assign sw_s    = sw_sync2_q;

    // Next-state, debounce counter and capture logic
    always_comb begin
        start_sync_d = {start_sync_q[0], bus.start};
        sw_sync1_d   = bus.sw;
        sw_sync2_d   = sw_sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        qual_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = ARM;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ARM: begin
                if (!start_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                    qual_s  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!start_s) begin
                    state_d = REL;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            REL: begin
                // A high sample here is release bounce, not a new press
                if (start_s) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        go_d  = qual_s & ~bus.busy;
        rej_d = qual_s &  bus.busy;

        if (go_d) begin
            sw_lat_d    = sw_s;
            ones_d      = popcnt(sw_s);
            press_cnt_d = press_cnt_q + 8'd1;
        end else begin
            sw_lat_d    = sw_lat_q;
            ones_d      = ones_q;
            press_cnt_d = press_cnt_q;
        end

        sw_chg_d = (sw_s != sw_lat_q);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_sync_q <= 2'b00;
            sw_sync1_q   <= '0;
            sw_sync2_q   <= '0;
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            go_q         <= 1'b0;
            rej_q        <= 1'b0;
            sw_lat_q     <= '0;
            ones_q       <= 3'd0;
            press_cnt_q  <= 8'd0;
            sw_chg_q     <= 1'b0;
        end else begin
            start_sync_q <= start_sync_d;
            sw_sync1_q   <= sw_sync1_d;
            sw_sync2_q   <= sw_sync2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            go_q         <= go_d;
            rej_q        <= rej_d;
            sw_lat_q     <= sw_lat_d;
            ones_q       <= ones_d;
            press_cnt_q  <= press_cnt_d;
            sw_chg_q     <= sw_chg_d;
        end
    end

    assign bus.go        = go_q;
    assign bus.rej       = rej_q;
    assign bus.sw_q      = sw_lat_q;
    assign bus.ones      = ones_q;
    assign bus.press_cnt = press_cnt_q;
    assign bus.sw_chg    = sw_chg_q;
endmodule

// File: tb/tb_start_sw_capture.sv
// Scoreboard bench for start_sw_capture: each accepted press pushes its expected
// capture; the monitor pops and compares whenever go is seen.
`timescale 1ns/1ps
module tb_start_sw_capture;
    logic clk;
    logic rst;

    start_sw_capture_if #(.SW_W(7)) bus ();

    start_sw_capture #(.SW_W(7), .DB_CYCLES(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int go_cycles = 0;
    int rej_cycles = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [6:0] exp_sw = 7'd0;
    logic [17:0] exp_q[$];

    // Expected capture for an accepted press: {sw_q, ones, press_cnt}
    task automatic push_exp(input logic [6:0] s);
        logic [2:0] n;
        n = 3'($countones(s));
        exp_cnt = exp_cnt + 8'd1;
        exp_sw  = s;
        exp_q.push_back({s, n, exp_cnt});
    endtask

    task automatic press(input int len, input int gap);
        @(negedge clk);
        bus.start = 1'b1;
        repeat (len) @(negedge clk);
        bus.start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.go === 1'b1) begin
            logic [17:0] e;
            go_cycles++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_go: got sw_q=%h ones=%0d cnt=%0d, expected no go",
                         bus.sw_q, bus.ones, bus.press_cnt);
            end else begin
                e = exp_q.pop_front();
                if ({bus.sw_q, bus.ones, bus.press_cnt} !== e) begin
                    fails++;
                    $display("FAIL sb_capture: got sw_q=%h ones=%0d cnt=%0d, expected sw_q=%h ones=%0d cnt=%0d",
                             bus.sw_q, bus.ones, bus.press_cnt, e[17:11], e[10:8], e[7:0]);
                end
            end
        end
        if (bus.rej === 1'b1) rej_cycles++;
    end

    task automatic test_reset();
        int n;
        rst = 1'b0;
        bus.start = 1'b1;
        bus.sw = 7'h7F;
        bus.busy = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({bus.go, bus.rej, bus.sw_q, bus.ones, bus.press_cnt, bus.sw_chg} !== 20'd0) begin
            fails++;
            $display("FAIL reset_outputs: got go=%b rej=%b sw_q=%h ones=%0d cnt=%0d chg=%b, expected all 0",
                     bus.go, bus.rej, bus.sw_q, bus.ones, bus.press_cnt, bus.sw_chg);
        end
        tests++;
        if (dut.state_q !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d, expected 0 (IDLE)", dut.state_q);
        end
        push_exp(7'h7F);
        rst = 1'b1;
        n = 0;
        while (bus.go !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL reset_go_latency: got go after %0d edges, expected 10", n);
        end
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_normal();
        int g0;
        g0 = go_cycles;
        bus.sw = 7'b0101011;
        for (int i = 0; i < 3; i++) begin
            push_exp(7'b0101011);
            press(10, 14);
        end
        tests++;
        if (go_cycles - g0 !== 3) begin
            fails++;
            $display("FAIL normal_go_count: got %0d, expected 3", go_cycles - g0);
        end
        tests++;
        if ({bus.sw_q, bus.ones, bus.press_cnt} !== {7'h2B, 3'd4, 8'd4}) begin
            fails++;
            $display("FAIL normal_capture: got sw_q=%h ones=%0d cnt=%0d, expected sw_q=2b ones=4 cnt=4",
                     bus.sw_q, bus.ones, bus.press_cnt);
        end
    endtask

    // Longest pulse that must still be ignored (eight synchronized samples qualify)
    task automatic test_glitch();
        int g0, r0;
        g0 = go_cycles;
        r0 = rej_cycles;
        bus.sw = 7'h55;
        press(7, 14);
        tests++;
        if ((go_cycles - g0) !== 0 || (rej_cycles - r0) !== 0) begin
            fails++;
            $display("FAIL glitch_strobes: got go=%0d rej=%0d, expected 0/0", go_cycles - g0, rej_cycles - r0);
        end
        tests++;
        if ({bus.sw_q, bus.press_cnt, bus.sw_chg} !== {exp_sw, exp_cnt, 1'b1}) begin
            fails++;
            $display("FAIL glitch_hold: got sw_q=%h cnt=%0d chg=%b, expected sw_q=%h cnt=%0d chg=1",
                     bus.sw_q, bus.press_cnt, bus.sw_chg, exp_sw, exp_cnt);
        end
    endtask

    task automatic test_bounce();
        int g0;
        g0 = go_cycles;
        bus.sw = 7'h0F;
        push_exp(7'h0F);
        @(negedge clk);
        bus.start = 1'b1;
        repeat (12) @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        tests++;
        if (go_cycles - g0 !== 1) begin
            fails++;
            $display("FAIL bounce_go_count: got %0d, expected 1", go_cycles - g0);
        end
        tests++;
        if (dut.state_q !== 2'd0) begin
            fails++;
            $display("FAIL bounce_end_state: got %0d, expected 0 (IDLE)", dut.state_q);
        end
    endtask

    task automatic test_busy_swchg();
        int g0, r0;
        g0 = go_cycles;
        r0 = rej_cycles;
        bus.sw = exp_sw;
        bus.busy = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        repeat (14) @(negedge clk);
        tests++;
        if ((rej_cycles - r0) !== 1 || (go_cycles - g0) !== 0) begin
            fails++;
            $display("FAIL busy_strobes: got rej=%0d go=%0d, expected 1/0", rej_cycles - r0, go_cycles - g0);
        end
        bus.sw = 7'h70;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.sw_chg !== 1'b0) begin
            fails++;
            $display("FAIL swchg_early: got %b after 2 edges, expected 0", bus.sw_chg);
        end
        @(negedge clk);
        tests++;
        if (bus.sw_chg !== 1'b1) begin
            fails++;
            $display("FAIL swchg_3edges: got %b, expected 1", bus.sw_chg);
        end
        tests++;
        if ({bus.sw_q, bus.press_cnt} !== {exp_sw, exp_cnt}) begin
            fails++;
            $display("FAIL busy_hold: got sw_q=%h cnt=%0d, expected sw_q=%h cnt=%0d",
                     bus.sw_q, bus.press_cnt, exp_sw, exp_cnt);
        end
        bus.start = 1'b0;
        bus.busy = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_wrap();
        int g0, n;
        logic [6:0] s;
        g0 = go_cycles;
        n = 256 - int'(exp_cnt);
        for (int i = 0; i < n; i++) begin
            s = 7'($urandom_range(0, 127));
            bus.sw = s;
            push_exp(s);
            press(10, 14);
        end
        tests++;
        if (go_cycles - g0 !== n) begin
            fails++;
            $display("FAIL wrap_go_count: got %0d, expected %0d", go_cycles - g0, n);
        end
        tests++;
        if (bus.press_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_cnt: got %0d, expected 0", bus.press_cnt);
        end
    endtask

    task automatic test_midreset();
        int g0;
        g0 = go_cycles;
        bus.sw = 7'h00;
        @(negedge clk);
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        #0.5 rst = 1'b0;
        #0.2;
        tests++;
        if ({bus.go, bus.rej, bus.sw_q, bus.ones, bus.press_cnt, bus.sw_chg} !== 20'd0 || dut.state_q !== 2'd0) begin
            fails++;
            $display("FAIL midreset_async: got go=%b rej=%b sw_q=%h ones=%0d cnt=%0d chg=%b st=%0d, expected all 0",
                     bus.go, bus.rej, bus.sw_q, bus.ones, bus.press_cnt, bus.sw_chg, dut.state_q);
        end
        exp_cnt = 8'd0;
        exp_sw = 7'd0;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if ((go_cycles - g0) !== 0 || bus.press_cnt !== 8'd0 || bus.sw_q !== 7'd0) begin
            fails++;
            $display("FAIL midreset_nogo: got go=%0d cnt=%0d sw_q=%h, expected 0/0/00",
                     go_cycles - g0, bus.press_cnt, bus.sw_q);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending captures, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.sw = 7'h00;
        bus.busy = 1'b0;
        @(negedge clk);
        test_reset();
        test_normal();
        test_glitch();
        test_bounce();
        test_busy_swchg();
        test_wrap();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
